// File: rtl/tx_frame_pkg.sv
// Shared types and constants for the Tx frame builder.
// TX_FRAME_CRC16_EN adds the CRC state to the FSM encoding.
package tx_frame_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hD391;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SYNC, S_LEN, S_PLD,
`ifdef TX_FRAME_CRC16_EN
    S_CRC,
`endif
    S_GAP
  } state_e;
endpackage

// File: rtl/tx_crc16_step.sv
// One-beat CRC-16/CCITT update, BYTES bytes per beat, MSB byte first.
module tx_crc16_step import tx_frame_pkg::*; #(
  parameter int BYTES = 1
) (
  input  logic [15:0]        crc_i,
  input  logic [8*BYTES-1:0] data_i,
  output logic [15:0]        crc_o
);
  always_comb begin
    logic [15:0] c;
    c = crc_i;
    for (int b = BYTES - 1; b >= 0; b--) begin
      c = c ^ {data_i[b*8 +: 8], 8'h00};
      for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    crc_o = c;
  end
endmodule

// File: rtl/tx_frame_builder.sv
// Frames a payload stream: preamble, sync, length, payload, optional CRC, gap.
// Define TX_FRAME_CRC16_EN to append a CRC-16/CCITT after the payload.
module tx_frame_builder import tx_frame_pkg::*; #(
  parameter int          BYTES        = 1,
  parameter int          PREAMBLE_LEN = 8,
  parameter logic [15:0] SYNC_WORD    = SYNC_WORD_DEF,
  parameter int          IFG_BEATS    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_enable,
  input  logic               en,
  input  logic [15:0]        payload_length,
  input  logic [8*BYTES-1:0] I_tdata,
  input  logic               I_tvalid,
  output logic               I_tready,
  input  logic               I_tlast,
  output logic [8*BYTES-1:0] O_tdata,
  output logic               O_tvalid,
  input  logic               O_tready,
  output logic               O_tlast,
  output logic               O_tuser,
  output logic               hdr_vld,
  output logic               pld_vld,
  output logic               pkt_sent,
  output logic               err_short,
  output logic               err_long
);
  localparam int DATA_W = 8 * BYTES;
  localparam int HB     = 2 / BYTES;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d, len_q, len_d;
  logic                pad_q, pad_d, drain_q, drain_d;
  logic                err_short_q, err_short_d, err_long_q, err_long_d;
  logic [DATA_W-1:0]   o_tdata_q, o_tdata_d;
  logic                o_tvalid_q, o_tvalid_d, o_tlast_q, o_tlast_d, o_tuser_q, o_tuser_d;
  logic                hdr_vld_q, pld_vld_q, pkt_sent_q, pkt_sent_d;
  logic                ld, hb_last, pld_last, frame_end;
  logic [15:0]         sync_sh, len_sh;
  logic [DATA_W-1:0]   sync_chunk, len_chunk;

  // Output register accepts a new beat when empty or being drained downstream.
  assign ld         = clk_enable & (~o_tvalid_q | O_tready);
  assign hb_last    = (cnt_q == 16'(HB - 1));
  assign pld_last   = (cnt_q == len_q - 16'd1);
  assign sync_sh    = SYNC_WORD << (DATA_W * cnt_q);
  assign len_sh     = len_q << (DATA_W * cnt_q);
  assign sync_chunk = sync_sh[15 -: DATA_W];
  assign len_chunk  = len_sh[15 -: DATA_W];

`ifdef TX_FRAME_CRC16_EN
  logic [15:0]       crc_q, crc_d, crc_nxt, crc_sh;
  logic [DATA_W-1:0] crc_in, crc_chunk;
  assign crc_in    = (state_q == S_LEN) ? len_chunk : (pad_q ? '0 : I_tdata);
  assign crc_sh    = crc_q << (DATA_W * cnt_q);
  assign crc_chunk = crc_sh[15 -: DATA_W];
  tx_crc16_step #(.BYTES(BYTES)) u_crc (.crc_i(crc_q), .data_i(crc_in), .crc_o(crc_nxt));
`endif

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; len_d = len_q; pad_d = pad_q; drain_d = drain_q;
    err_short_d = err_short_q; err_long_d = err_long_q;
    o_tdata_d = o_tdata_q; o_tvalid_d = o_tvalid_q; o_tlast_d = o_tlast_q; o_tuser_d = o_tuser_q;
    I_tready = 1'b0; frame_end = 1'b0;
`ifdef TX_FRAME_CRC16_EN
    crc_d = crc_q;
`endif
    if (ld) begin
      o_tvalid_d = 1'b0; o_tdata_d = '0; o_tlast_d = 1'b0; o_tuser_d = 1'b0;
    end
    case (state_q)
      S_IDLE: if (clk_enable && en) begin
        len_d = payload_length; cnt_d = '0; pad_d = 1'b0; drain_d = 1'b0; state_d = S_PRE;
`ifdef TX_FRAME_CRC16_EN
        crc_d = CRC16_INIT;
`endif
      end
      S_PRE: if (ld) begin
        o_tvalid_d = 1'b1; o_tuser_d = 1'b1; o_tdata_d = {BYTES{PREAMBLE_BYTE}};
        if (cnt_q == 16'(PREAMBLE_LEN - 1)) begin cnt_d = '0; state_d = S_SYNC; end
        else cnt_d = cnt_q + 16'd1;
      end
      S_SYNC: if (ld) begin
        o_tvalid_d = 1'b1; o_tuser_d = 1'b1; o_tdata_d = sync_chunk;
        if (hb_last) begin cnt_d = '0; state_d = S_LEN; end
        else cnt_d = cnt_q + 16'd1;
      end
      S_LEN: if (ld) begin
        o_tvalid_d = 1'b1; o_tuser_d = 1'b1; o_tdata_d = len_chunk;
`ifdef TX_FRAME_CRC16_EN
        crc_d = crc_nxt;
`endif
        if (hb_last) begin
          cnt_d = '0;
          if (len_q == 16'd0) frame_end = 1'b1;
          else state_d = S_PLD;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_PLD: begin
        // After an early I_tlast the rest of the payload is zero padding.
        I_tready = ld & ~pad_q;
        if (ld && (pad_q || I_tvalid)) begin
          o_tvalid_d = 1'b1; o_tdata_d = pad_q ? '0 : I_tdata;
`ifdef TX_FRAME_CRC16_EN
          crc_d = crc_nxt;
`endif
          if (!pad_q && I_tlast && !pld_last) begin pad_d = 1'b1; err_short_d = 1'b1; end
          if (!pad_q && !I_tlast && pld_last) begin drain_d = 1'b1; err_long_d = 1'b1; end
          if (pld_last) begin cnt_d = '0; frame_end = 1'b1; end
          else cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef TX_FRAME_CRC16_EN
      S_CRC: if (ld) begin
        o_tvalid_d = 1'b1; o_tdata_d = crc_chunk;
        if (hb_last) begin cnt_d = '0; o_tlast_d = 1'b1; state_d = S_GAP; end
        else cnt_d = cnt_q + 16'd1;
      end
`endif
      S_GAP: begin
        // Overlong input is swallowed here; the gap lasts until it is gone.
        I_tready = clk_enable & drain_q;
        if (clk_enable && drain_q && I_tvalid && I_tlast) drain_d = 1'b0;
        if (ld) begin
          if (int'(cnt_q) >= IFG_BEATS && !drain_q) begin cnt_d = '0; state_d = S_IDLE; end
          else if (int'(cnt_q) < IFG_BEATS) cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (frame_end) begin
`ifdef TX_FRAME_CRC16_EN
      state_d = S_CRC;
`else
      o_tlast_d = 1'b1; state_d = S_GAP;
`endif
    end
  end

  assign pkt_sent_d = clk_enable & o_tvalid_q & O_tready & o_tlast_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; cnt_q <= '0; len_q <= '0; pad_q <= 1'b0; drain_q <= 1'b0;
      err_short_q <= 1'b0; err_long_q <= 1'b0;
      o_tdata_q <= '0; o_tvalid_q <= 1'b0; o_tlast_q <= 1'b0; o_tuser_q <= 1'b0;
      hdr_vld_q <= 1'b0; pld_vld_q <= 1'b0; pkt_sent_q <= 1'b0;
`ifdef TX_FRAME_CRC16_EN
      crc_q <= CRC16_INIT;
`endif
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; len_q <= len_d; pad_q <= pad_d; drain_q <= drain_d;
      err_short_q <= err_short_d; err_long_q <= err_long_d;
      o_tdata_q <= o_tdata_d; o_tvalid_q <= o_tvalid_d; o_tlast_q <= o_tlast_d; o_tuser_q <= o_tuser_d;
      hdr_vld_q <= o_tvalid_d & o_tuser_d; pld_vld_q <= o_tvalid_d & ~o_tuser_d;
      pkt_sent_q <= pkt_sent_d;
`ifdef TX_FRAME_CRC16_EN
      crc_q <= crc_d;
`endif
    end
  end

  assign O_tdata   = o_tdata_q;
  assign O_tvalid  = o_tvalid_q;
  assign O_tlast   = o_tlast_q;
  assign O_tuser   = o_tuser_q;
  assign hdr_vld   = hdr_vld_q;
  assign pld_vld   = pld_vld_q;
  assign pkt_sent  = pkt_sent_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
endmodule

// File: tb/tb_tx_frame_builder.sv
// Randomized bench for tx_frame_builder against a frame-level reference model.
module tb_tx_frame_builder;
  localparam int PL  = 2;
  localparam int IFG = 2;

  logic clk = 1'b0, rst = 1'b1, clk_enable = 1'b0, en = 1'b0;
  logic [15:0] payload_length = '0;
  logic [7:0] I_tdata = '0;
  logic I_tvalid = 1'b0, I_tlast = 1'b0, O_tready = 1'b1;
  logic I_tready, O_tvalid, O_tlast, O_tuser, hdr_vld, pld_vld, pkt_sent, err_short, err_long;
  logic [7:0] O_tdata;

  typedef struct packed { logic [7:0] d; logic u; logic l; } beat_t;
  typedef struct packed { logic [7:0] d; logic l; } src_t;

  beat_t exp_q[$], cap_q[$];
  src_t  src_q[$], stage_q[$];
  int    cap_t[$];
  int    n_cmp = 0, n_err = 0, ecnt = 0, pkt_cnt = 0, stab_viol = 0, aux_viol = 0, last_t = 0;
  bit    rnd_rdy = 1'b0, exp_es = 1'b0, exp_el = 1'b0;

  always #5 clk = ~clk;

  tx_frame_builder #(.BYTES(1), .PREAMBLE_LEN(PL), .SYNC_WORD(16'hD391), .IFG_BEATS(IFG)) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .en(en), .payload_length(payload_length),
    .I_tdata(I_tdata), .I_tvalid(I_tvalid), .I_tready(I_tready), .I_tlast(I_tlast),
    .O_tdata(O_tdata), .O_tvalid(O_tvalid), .O_tready(O_tready), .O_tlast(O_tlast),
    .O_tuser(O_tuser), .hdr_vld(hdr_vld), .pld_vld(pld_vld), .pkt_sent(pkt_sent),
    .err_short(err_short), .err_long(err_long));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {O_tvalid, O_tdata, O_tlast, O_tuser, hdr_vld, pld_vld, pkt_sent, err_short, err_long, I_tready};
  endfunction

`ifdef TX_FRAME_CRC16_EN
  function automatic logic [15:0] crc8(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction
`endif

  // Beat pump: clock enable, source queue, ready pattern, capture and protocol watchers.
  initial begin
    int cc; bit in_f; bit hold_v; logic [10:0] held;
    cc = 0; in_f = 1'b0; hold_v = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (in_f && src_q.size() > 0) void'(src_q.pop_front());
      cc = (cc + 1) % 32;
      clk_enable = (cc == 0);
      if (clk_enable) ecnt++;
      O_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (src_q.size() > 0) begin
        I_tvalid = 1'b1; I_tdata = src_q[0].d; I_tlast = src_q[0].l;
      end else begin
        I_tvalid = 1'b0; I_tdata = '0; I_tlast = 1'b0;
      end
      #1;
      in_f = I_tvalid & I_tready;
      if (pkt_sent) pkt_cnt++;
      if (hdr_vld !== (O_tvalid & O_tuser) || pld_vld !== (O_tvalid & ~O_tuser)) aux_viol++;
      if (rst) hold_v = 1'b0;
      else begin
        if (hold_v && {O_tvalid, O_tdata, O_tlast, O_tuser} !== held) stab_viol++;
        if (clk_enable && O_tvalid) begin
          if (O_tready) begin
            hold_v = 1'b0;
            cap_q.push_back({O_tdata, O_tuser, O_tlast});
            cap_t.push_back(ecnt);
          end else begin
            hold_v = 1'b1; held = {O_tvalid, O_tdata, O_tlast, O_tuser};
          end
        end
      end
    end
  end

  task automatic add(input logic [7:0] d, input logic l);
    stage_q.push_back({d, l});
  endtask

  // Reference frame: header, len beats (padding after early tlast), optional CRC.
  task automatic build(input int len, output bit fs, output bit fl);
    bit got; logic [7:0] b; logic [15:0] l16; beat_t t;
`ifdef TX_FRAME_CRC16_EN
    logic [15:0] c;
`endif
    l16 = 16'(len); got = 1'b0; fs = 1'b0;
    exp_q.delete();
    for (int i = 0; i < PL; i++) exp_q.push_back({8'h55, 2'b10});
    exp_q.push_back({8'hD3, 2'b10}); exp_q.push_back({8'h91, 2'b10});
    exp_q.push_back({l16[15:8], 2'b10}); exp_q.push_back({l16[7:0], 2'b10});
`ifdef TX_FRAME_CRC16_EN
    c = crc8(crc8(16'hFFFF, l16[15:8]), l16[7:0]);
`endif
    for (int k = 0; k < len; k++) begin
      if (got) b = 8'h00;
      else begin
        b = stage_q[k].d; got = stage_q[k].l;
        if (got && k < len - 1) fs = 1'b1;
      end
      exp_q.push_back({b, 2'b00});
`ifdef TX_FRAME_CRC16_EN
      c = crc8(c, b);
`endif
    end
    fl = (len > 0) && !got;
`ifdef TX_FRAME_CRC16_EN
    exp_q.push_back({c[15:8], 2'b00}); exp_q.push_back({c[7:0], 2'b00});
`endif
    t = exp_q.pop_back(); t.l = 1'b1; exp_q.push_back(t);
  endtask

  task automatic run_frame(input int len, input bit hold);
    bit fs, fl; int t, n;
    build(len, fs, fl);
    foreach (stage_q[i]) src_q.push_back(stage_q[i]);
    stage_q.delete();
    cap_q.delete(); cap_t.delete();
    payload_length = 16'(len); en = 1'b1;
    t = 0;
    while (cap_q.size() == 0 && t < 3000) begin @(negedge clk); t++; end
    en = hold;
    while (cap_q.size() < exp_q.size() && t < 8000) begin @(negedge clk); t++; end
    chk("nbeats", cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("beat%0d", i), cap_q[i], exp_q[i]);
    if (cap_t.size() > 0) begin
      if (last_t > 0) chk("ifg", (cap_t[0] - last_t - 1) >= IFG, 1);
      last_t = cap_t[cap_t.size() - 1];
    end
    if (!hold) begin
      t = 0;
      while (src_q.size() > 0 && t < 3000) begin @(negedge clk); t++; end
      chk("drain", src_q.size(), 0);
      repeat ((IFG + 4) * 32) @(negedge clk);
      chk("extra", cap_q.size(), exp_q.size());
    end
    exp_es |= fs; exp_el |= fl;
    chk("err_short", err_short, exp_es);
    chk("err_long", err_long, exp_el);
  endtask

  initial begin
    int p0, t, len, j;
    repeat (4) @(negedge clk);
    #2 chk("rst_outs", outs(), 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #2 chk("idle_outs", outs(), 0);

    // T1 nominal
    p0 = pkt_cnt;
    add(8'h01, 0); add(8'h02, 0); add(8'h03, 1);
    run_frame(3, 0);
    chk("pkt_t1", pkt_cnt - p0, 1);
    // T2 single byte payload
    add(8'hA5, 1);
    run_frame(1, 0);
    // zero length: header only
    p0 = pkt_cnt;
    run_frame(0, 0);
    chk("pkt_len0", pkt_cnt - p0, 1);
    // T5 downstream backpressure
    rnd_rdy = 1'b1;
    add(8'h01, 0); add(8'h02, 0); add(8'h03, 1);
    run_frame(3, 0);
    rnd_rdy = 1'b0;
    chk("stable_t5", stab_viol, 0);

    // T3 short frame, then a back-to-back frame with en held
    p0 = pkt_cnt;
    add(8'h11, 0); add(8'h22, 1);
    run_frame(4, 1);
    add(8'h31, 0); add(8'h32, 0); add(8'h33, 1);
    run_frame(3, 0);
    chk("pkt_t3", pkt_cnt - p0, 2);
    // T4 long frame with drain
    add(8'h41, 0); add(8'h42, 0); add(8'h43, 0); add(8'h44, 0); add(8'h45, 1);
    run_frame(2, 0);
    add(8'h51, 0); add(8'h52, 1);
    run_frame(2, 0);

    // Random frames: normal, short and long mixes under random ready
    rnd_rdy = 1'b1;
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 5);
      case ($urandom_range(0, 2))
        0: for (int k = 0; k < len; k++) add(8'($urandom), k == len - 1);
        1: begin
          j = $urandom_range(0, len - 1);
          for (int k = 0; k <= j; k++) add(8'($urandom), k == j);
        end
        default: begin
          j = len + $urandom_range(1, 3);
          for (int k = 0; k < j; k++) add(8'($urandom), k == j - 1);
        end
      endcase
      run_frame(len, 0);
    end
    rnd_rdy = 1'b0;

    // T6 reset during payload
    p0 = pkt_cnt;
    for (int k = 0; k < 6; k++) src_q.push_back({8'(8'h60 + k), k == 5});
    payload_length = 16'd6; en = 1'b1;
    t = 0;
    while (!(O_tvalid && !O_tuser) && t < 3000) begin @(negedge clk); #2; t++; end
    chk("t6_pld_seen", O_tvalid && !O_tuser, 1);
    en = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;
    #1 chk("t6_rst_outs", outs(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    src_q.delete(); stage_q.delete();
    exp_es = 1'b0; exp_el = 1'b0; last_t = 0;
    repeat (3 * 32) @(negedge clk);
    #2 chk("t6_outs_after", outs(), 0);
    chk("t6_no_pkt", pkt_cnt - p0, 0);
    add(8'h71, 0); add(8'h72, 0); add(8'h73, 1);
    run_frame(3, 0);
    chk("t6_pkt", pkt_cnt - p0, 1);

    chk("hdr_pld_vld", aux_viol, 0);
    chk("stable_all", stab_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
